// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared constants for the iterative signed multiply/divide unit.
// Optional build macro MULTDIV_BOOTH4_EN selects radix-4 Booth multiply
// (WIDTH/2 iterations) instead of radix-2 shift-add (WIDTH iterations).
package multdiv_pkg;

    // Controller state encoding (legacy-compatible constants)
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Op-select encoding for the shared adder/subtractor
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

`ifdef MULTDIV_BOOTH4_EN
    localparam int unsigned MUL_BITS_PER_ITER = 2;
`else
    localparam int unsigned MUL_BITS_PER_ITER = 1;
`endif

    // Number of multiply iterations for a given operand width
    function automatic int unsigned iter_mul(input int unsigned width);
        return width / MUL_BITS_PER_ITER;
    endfunction

    // Number of divide iterations (sign correction adds one more cycle)
    function automatic int unsigned iter_div(input int unsigned width);
        return width;
    endfunction

endpackage

// File: rtl/multdiv_addsub.sv
// multdiv_addsub: plain two's-complement adder/subtractor shared by the
// multiply and divide datapaths.
module multdiv_addsub #(
    parameter int unsigned AW = 34
) (
    input  logic [AW-1:0] a_i,
    input  logic [AW-1:0] b_i,
    input  logic          sub_i,
    output logic [AW-1:0] sum_o
);

    // sub_i selects a_i - b_i, otherwise a_i + b_i
    always_comb begin
        sum_o = sub_i ? (a_i - b_i) : (a_i + b_i);
    end

endmodule

// File: rtl/multdiv_unit.sv
// multdiv_unit: iterative signed multiply (low word + overflow flag) and
// signed non-restoring divide (quotient truncated toward zero).
// Build macro MULTDIV_BOOTH4_EN: radix-4 Booth multiply; undefined: radix-2.
module multdiv_unit
    import multdiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             ctrl_mult,
    input  logic             ctrl_div,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic [WIDTH-1:0] result,
    output logic             exception,
    output logic             result_rdy,
    output logic             busy
);

    localparam int unsigned AW       = WIDTH + 2;
    localparam int unsigned ITER_MUL = iter_mul(WIDTH);
    localparam int unsigned ITER_DIV = iter_div(WIDTH);
    localparam int unsigned CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]    MUL_LAST = CW'(ITER_MUL - 1);
    localparam logic [CW-1:0]    DIV_FIX  = CW'(ITER_DIV);
    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [AW-1:0]    hi_q, hi_d;       // mult accumulator / div partial remainder
    logic [WIDTH-1:0] lo_q, lo_d;       // mult multiplier bits / div quotient bits
    logic [WIDTH-1:0] mc_q, mc_d;       // multiplicand / divisor magnitude
    logic             neg_q, neg_d;
    logic             dz_q, dz_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             exc_q, exc_d;
`ifdef MULTDIV_BOOTH4_EN
    logic             ext_q, ext_d;     // Booth look-behind bit
`endif

    logic [AW-1:0]    add_x, add_y, add_sum;
    logic             add_sub;
    logic [AW-1:0]    mc_ext, r_sh, mhi;
    logic [WIDTH-1:0] mlo, dlo, a_mag, b_mag;
    logic             mul_ovf;

    assign mc_ext = {{2{mc_q[WIDTH-1]}}, mc_q};
    assign r_sh   = {hi_q[AW-2:0], lo_q[WIDTH-1]};
    assign a_mag  = operand_a[WIDTH-1] ? (~operand_a + WIDTH'(1)) : operand_a;
    assign b_mag  = operand_b[WIDTH-1] ? (~operand_b + WIDTH'(1)) : operand_b;

    assign result     = result_q;
    assign exception  = exc_q;
    assign result_rdy = (state_q == ST_DONE);
    assign busy       = (state_q == ST_MUL) || (state_q == ST_DIV);

    multdiv_addsub #(.AW(AW)) u_addsub (
        .a_i   (add_x),
        .b_i   (add_y),
        .sub_i (add_sub),
        .sum_o (add_sum)
    );

    // Steer the shared adder for the current multiply/divide step
    always_comb begin
        add_x   = '0;
        add_y   = '0;
        add_sub = OP_ADD;
        case (state_q)
            ST_MUL: begin
                add_x = hi_q;
`ifdef MULTDIV_BOOTH4_EN
                case ({lo_q[1:0], ext_q})
                    3'b001, 3'b010: add_y = mc_ext;
                    3'b011:         add_y = {mc_q[WIDTH-1], mc_q, 1'b0};
                    3'b100: begin
                        add_y   = {mc_q[WIDTH-1], mc_q, 1'b0};
                        add_sub = OP_SUB;
                    end
                    3'b101, 3'b110: begin
                        add_y   = mc_ext;
                        add_sub = OP_SUB;
                    end
                    default:        add_y = '0;
                endcase
`else
                // Multiplier sign bit carries weight -2^(WIDTH-1): subtract on last step
                add_y   = lo_q[0] ? mc_ext : '0;
                add_sub = (cnt_q == MUL_LAST) ? OP_SUB : OP_ADD;
`endif
            end
            ST_DIV: begin
                if (cnt_q == DIV_FIX) begin
                    add_x   = '0;
                    add_y   = {2'b00, lo_q};
                    add_sub = OP_SUB;
                end else begin
                    add_x   = r_sh;
                    add_y   = {2'b00, mc_q};
                    add_sub = hi_q[AW-1] ? OP_ADD : OP_SUB;
                end
            end
            default: ;
        endcase
    end

    // Shift the adder output back into the accumulator/quotient pair
    always_comb begin
`ifdef MULTDIV_BOOTH4_EN
        mhi = {{2{add_sum[AW-1]}}, add_sum[AW-1:2]};
        mlo = {add_sum[1:0], lo_q[WIDTH-1:2]};
`else
        mhi = {add_sum[AW-1], add_sum[AW-1:1]};
        mlo = {add_sum[0], lo_q[WIDTH-1:1]};
`endif
        mul_ovf = (mhi != {AW{mlo[WIDTH-1]}});
        dlo     = {lo_q[WIDTH-2:0], ~add_sum[AW-1]};
    end

    // Controller and datapath next-state
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        mc_d     = mc_q;
        neg_d    = neg_q;
        dz_d     = dz_q;
        ovf_d    = ovf_q;
        result_d = result_q;
        exc_d    = exc_q;
`ifdef MULTDIV_BOOTH4_EN
        ext_d    = ext_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (ctrl_mult) begin
                    state_d = ST_MUL;
                    cnt_d   = '0;
                    hi_d    = '0;
                    lo_d    = operand_b;
                    mc_d    = operand_a;
`ifdef MULTDIV_BOOTH4_EN
                    ext_d   = 1'b0;
`endif
                end else if (ctrl_div) begin
                    // Divide on magnitudes; the sign is applied in a final cycle
                    state_d = ST_DIV;
                    cnt_d   = '0;
                    hi_d    = '0;
                    lo_d    = a_mag;
                    mc_d    = b_mag;
                    neg_d   = operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
                    dz_d    = (operand_b == '0);
                    ovf_d   = (operand_a == MIN_VAL) && (operand_b == '1);
                end
            end
            ST_MUL: begin
                hi_d  = mhi;
                lo_d  = mlo;
                cnt_d = cnt_q + CW'(1);
`ifdef MULTDIV_BOOTH4_EN
                ext_d = lo_q[1];
`endif
                if (cnt_q == MUL_LAST) begin
                    state_d  = ST_DONE;
                    result_d = mlo;
                    exc_d    = mul_ovf;
                end
            end
            ST_DIV: begin
                if (dz_q) begin
                    state_d  = ST_DONE;
                    result_d = '0;
                    exc_d    = 1'b1;
                end else if (cnt_q == DIV_FIX) begin
                    state_d  = ST_DONE;
                    result_d = neg_q ? add_sum[WIDTH-1:0] : lo_q;
                    exc_d    = ovf_q;
                end else begin
                    hi_d  = add_sum;
                    lo_d  = dlo;
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with asynchronous active-low clear
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            mc_q     <= '0;
            neg_q    <= 1'b0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
`ifdef MULTDIV_BOOTH4_EN
            ext_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            mc_q     <= mc_d;
            neg_q    <= neg_d;
            dz_q     <= dz_d;
            ovf_q    <= ovf_d;
            result_q <= result_d;
            exc_q    <= exc_d;
`ifdef MULTDIV_BOOTH4_EN
            ext_q    <= ext_d;
`endif
        end
    end

endmodule

// File: tb/tb_multdiv_unit.sv
// tb_multdiv_unit: directed scoreboard bench for multdiv_unit (WIDTH 32).
module tb_multdiv_unit;

    localparam logic [31:0] MIN32 = 32'h8000_0000;
`ifdef MULTDIV_BOOTH4_EN
    localparam int MUL_LAT = 17;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 34;
    localparam int DZ_LAT  = 2;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        clr;
    logic        ctrl_mult, ctrl_div;
    logic [31:0] operand_a, operand_b;
    logic [31:0] result;
    logic        exception, result_rdy, busy;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    multdiv_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .clr        (clr),
        .ctrl_mult  (ctrl_mult),
        .ctrl_div   (ctrl_div),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .result     (result),
        .exception  (exception),
        .result_rdy (result_rdy),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input bit m, input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint p;
        int     q;
        if (m) begin
            p     = longint'($signed(a)) * longint'($signed(b));
            e.res = p[31:0];
            e.exc = (p != longint'($signed(p[31:0])));
            e.lat = MUL_LAT;
        end else if (b == 32'd0) begin
            e.res = 32'd0;
            e.exc = 1'b1;
            e.lat = DZ_LAT;
        end else if (a == MIN32 && b == 32'hFFFF_FFFF) begin
            e.res = MIN32;
            e.exc = 1'b1;
            e.lat = DIV_LAT;
        end else begin
            q     = $signed(a) / $signed(b);
            e.res = q;
            e.exc = 1'b0;
            e.lat = DIV_LAT;
        end
        return e;
    endfunction

    task automatic drive(input bit m, input logic [31:0] a, input logic [31:0] b);
        ctrl_mult = m;
        ctrl_div  = !m;
        operand_a = a;
        operand_b = b;
        sb.push_back(model(m, a, b));
    endtask

    // n0 = rising edges already seen since the accepting edge
    task automatic wait_result(input int n0, input bit pulse_chk);
        int   n;
        bit   got;
        exp_t e;
        n   = n0;
        got = 1'b0;
        while (!got && n < 200) begin
            if (result_rdy === 1'b1) got = 1'b1;
            else begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        check("rdy_seen", {63'd0, got}, 64'd1);
        if (sb.size() == 0) begin
            check("sb_nonempty", 64'd0, 64'd1);
        end else begin
            e = sb.pop_front();
            if (got) begin
                check("latency", 64'(n), 64'(e.lat - 1));
                check("result", {32'd0, result}, {32'd0, e.res});
                check("exception", {63'd0, exception}, {63'd0, e.exc});
                if (pulse_chk) begin
                    @(posedge clk);
                    #1;
                    check("rdy_single", {63'd0, result_rdy}, 64'd0);
                    check("result_hold", {32'd0, result}, {32'd0, e.res});
                    check("exc_hold", {63'd0, exception}, {63'd0, e.exc});
                end
            end
        end
    endtask

    task automatic finish_op(input bit pulse_chk);
        @(posedge clk);
        #1;
        ctrl_mult = 1'b0;
        ctrl_div  = 1'b0;
        operand_a = $urandom;
        operand_b = $urandom;
        check("busy_after_accept", {63'd0, busy}, 64'd1);
        wait_result(0, pulse_chk);
    endtask

    task automatic run_op(input bit m, input logic [31:0] a, input logic [31:0] b, input bit pulse_chk);
        @(negedge clk);
        drive(m, a, b);
        finish_op(pulse_chk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb;
        clr       = 1'b0;
        ctrl_mult = 1'b0;
        ctrl_div  = 1'b0;
        operand_a = '0;
        operand_b = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_result", {32'd0, result}, 64'd0);
        check("rst_exc", {63'd0, exception}, 64'd0);
        check("rst_rdy", {63'd0, result_rdy}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);

        // Start on the first rising edge after clr release
        @(negedge clk);
        clr = 1'b1;
        drive(1'b1, 32'd7, 32'hFFFF_FFFD);
        finish_op(1'b1);

        run_op(1'b1, 32'h0001_0000, 32'h0001_0000, 1'b1);
        run_op(1'b0, 32'd100, 32'hFFFF_FFF9, 1'b1);
        // Divide-by-zero then an immediate start while in DONE
        run_op(1'b0, 32'd5, 32'd0, 1'b0);
        run_op(1'b0, MIN32, 32'hFFFF_FFFF, 1'b1);
        run_op(1'b1, MIN32, 32'hFFFF_FFFF, 1'b1);
        run_op(1'b1, MIN32, 32'd1, 1'b1);
        run_op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        run_op(1'b0, 32'hFFFF_FFF9, 32'd2, 1'b1);
        run_op(1'b0, 32'd7, 32'hFFFF_FFFE, 1'b1);
        run_op(1'b0, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1);
        run_op(1'b0, MIN32, 32'd1, 1'b1);

        // Both start pulses high: multiply wins
        @(negedge clk);
        drive(1'b1, 32'd12, 32'd11);
        ctrl_div = 1'b1;
        finish_op(1'b1);

        for (int i = 0; i < 3; i++) begin
            ra = 32'($urandom_range(0, 60000)) - 32'd30000;
            rb = 32'($urandom_range(0, 60000)) - 32'd30000;
            run_op(1'b1, ra, rb, 1'b1);
            run_op(1'b0, $urandom, rb, 1'b1);
            run_op(1'b1, $urandom, $urandom, 1'b1);
        end

        // ctrl_div pulsed during cycle 5 of a multiply is ignored
        @(negedge clk);
        drive(1'b1, 32'd123, 32'hFFFF_FFD3);
        @(posedge clk);
        #1;
        ctrl_mult = 1'b0;
        ctrl_div  = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        ctrl_div  = 1'b1;
        operand_a = 32'd9;
        operand_b = 32'd3;
        @(posedge clk);
        #1;
        ctrl_div = 1'b0;
        wait_result(5, 1'b1);
        repeat (40) @(posedge clk);
        #1;
        check("no_extra_rdy", {63'd0, result_rdy}, 64'd0);
        check("no_extra_busy", {63'd0, busy}, 64'd0);

        // clr asserted mid-divide abandons it
        @(negedge clk);
        ctrl_div  = 1'b1;
        operand_a = 32'd1000;
        operand_b = 32'd3;
        @(posedge clk);
        #1;
        ctrl_div = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        clr = 1'b0;
        #1;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_result", {32'd0, result}, 64'd0);
        check("abort_exc", {63'd0, exception}, 64'd0);
        check("abort_rdy", {63'd0, result_rdy}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("abort_no_rdy", {63'd0, result_rdy}, 64'd0);
        end
        @(negedge clk);
        clr = 1'b1;
        drive(1'b1, 32'd2, 32'd3);
        finish_op(1'b1);

        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
